irq_trigger_scheduler: RTL and testbench

//  Synthesisable scheduler that drives the CPU's external interrupt line when the macro PC
//  (addr) reaches programmed trigger addresses. Holds a small table of trigger slots; on a

---
 rtl/irq_sched_pkg.sv | 30 +++
 rtl/irq_slot_match.sv | 60 ++++++
 rtl/irq_trigger_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_irq_trigger_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_sched_pkg.sv
// Shared types and constants for the interrupt trigger scheduler.
//   state_e  : scheduler FSM states
//   slot_t   : one trigger table entry (enable, chain, rearm, fired flag, trigger PC)
//   CNT_SAT  : saturation value of the 8-bit event counters
//   sat_inc  : saturating increment used by those counters
package irq_sched_pkg;

  // Trigger PCs are stored at this width; the top's ADDR_W must not exceed it.
  localparam int         MAX_ADDR_W = 32;
  localparam logic [7:0] CNT_SAT    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic                  en;
    logic                  chain;
    logic                  rearm;
    logic                  fired;
    logic [MAX_ADDR_W-1:0] pc;
  } slot_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/irq_slot_match.sv
// Trigger slot comparator array with stall filtering and priority select.
//   clk, reset : clock, async active-low reset
//   addr       : macro PC from the CPU
//   slots      : current trigger table contents
//   hit        : at least one slot requests service this cycle
//   hit_idx    : lowest-index requesting slot
// A slot requests only on the first cycle its PC is seen, so a CPU stalled on
// one address produces a single request.
module irq_slot_match
  import irq_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  slot_t             slots [NUM_SLOTS],
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx
);

  logic [NUM_SLOTS-1:0] raw;      // enabled slot whose word address equals addr
  logic [NUM_SLOTS-1:0] req;      // edge-qualified, arming-qualified request
  logic [NUM_SLOTS-1:0] prev_q;
  logic [NUM_SLOTS-1:0] prev_d;
  logic [NUM_SLOTS-1:0] unused_slot_bits;
  logic                 unused_addr_bits;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_cmp
    // Byte offset is ignored: triggers are word aligned.
    assign raw[i] = slots[i].en &
                    (addr[ADDR_W-1:2] == slots[i].pc[ADDR_W-1:2]);
    // One-shot slots stay silent once fired until rewritten.
    assign req[i] = raw[i] & ~prev_q[i] & (slots[i].rearm | ~slots[i].fired);
    assign unused_slot_bits[i] = slots[i].chain ^ (^slots[i].pc[1:0]);
  end

  assign unused_addr_bits = ^addr[1:0];
  assign prev_d           = raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= '0;
    else        prev_q <= prev_d;
  end

  // Scan high to low so the lowest requesting index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_trigger_scheduler.sv
// Drives the CPU external interrupt line when the macro PC reaches programmed
// trigger addresses.
//   clk, reset  : clock, async active-low reset
//   addr        : macro PC from the CPU, sampled every cycle
//   cfg_*       : single-slot table write (index, PC, enable, chain, rearm)
//   interrupt   : registered interrupt to the CPU
//   busy        : high while a pulse or the gap before a chained pulse runs
//   active_slot : slot being served, holds its last value when idle
//   fire_cnt    : pulses issued (saturating)
//   drop_cnt    : requests lost because the pending register was full (saturating)
module irq_trigger_scheduler
  import irq_sched_pkg::*;
#(
  parameter  int NUM_SLOTS = 4,
  parameter  int PULSE_LEN = 6,
  parameter  int GAP_LEN   = 1,
  parameter  int ADDR_W    = 32,
  localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_pc,
  input  logic              cfg_en,
  input  logic              cfg_chain,
  input  logic              cfg_rearm,
  output logic              interrupt,
  output logic              busy,
  output logic [IDX_W-1:0]  active_slot,
  output logic [7:0]        fire_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_LEN - 1);

  // ---------------------------------------------------------------- state
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               second_q, second_d;     // serving the chained pulse
  logic               pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
  logic [IDX_W-1:0]   active_q, active_d;
  logic [7:0]         fire_q, fire_d;
  logic [7:0]         drop_q, drop_d;
  logic               int_q, int_d;
  logic               busy_q, busy_d;
  slot_t              slot_q [NUM_SLOTS];
  slot_t              slot_d [NUM_SLOTS];

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               start;                  // begin a first pulse this cycle
  logic [IDX_W-1:0]   start_idx;
  logic               hit_used;               // hit launched a pulse directly

  irq_slot_match #(
    .NUM_SLOTS (NUM_SLOTS),
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W)
  ) u_match (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .slots   (slot_q),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    second_d   = second_q;
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
    active_d   = active_q;
    fire_d     = fire_q;
    drop_d     = drop_q;
    slot_d     = slot_q;
    start      = 1'b0;
    start_idx  = '0;
    hit_used   = 1'b0;

    case (state_q)
      IDLE: begin
        // Pending is older than any fresh hit, so it goes first.
        if (pend_vld_q) begin
          start      = 1'b1;
          start_idx  = pend_idx_q;
          pend_vld_d = 1'b0;
        end else if (hit) begin
          start                 = 1'b1;
          start_idx             = hit_idx;
          hit_used              = 1'b1;
          slot_d[hit_idx].fired = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          if (slot_q[active_q].chain && !second_q) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else if (pend_vld_q) begin
            // Back-to-back: no idle cycle between pulses.
            start      = 1'b1;
            start_idx  = pend_idx_q;
            pend_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d  = PULSE;
          cnt_d    = PULSE_LD;
          second_d = 1'b1;
          fire_d   = sat_inc(fire_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d  = PULSE;
      cnt_d    = PULSE_LD;
      second_d = 1'b0;
      active_d = start_idx;
      fire_d   = sat_inc(fire_q);
    end

    // A hit that did not launch a pulse is parked; the slot freed by a
    // pending launch in this same cycle may be refilled immediately.
    if (hit && !hit_used) begin
      if (!pend_vld_d) begin
        pend_vld_d            = 1'b1;
        pend_idx_d            = hit_idx;
        slot_d[hit_idx].fired = 1'b1;
      end else begin
        drop_d = sat_inc(drop_q);
      end
    end

    // Applied last so a write wins over a same-cycle fired update; the
    // matcher already used the old contents this cycle.
    if (cfg_we) begin
      slot_d[cfg_idx].en    = cfg_en;
      slot_d[cfg_idx].chain = cfg_chain;
      slot_d[cfg_idx].rearm = cfg_rearm;
      slot_d[cfg_idx].fired = 1'b0;
      slot_d[cfg_idx].pc    = MAX_ADDR_W'(cfg_pc);
    end

    int_d  = (state_d == PULSE);
    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------- flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      second_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      active_q   <= '0;
      fire_q     <= '0;
      drop_q     <= '0;
      int_q      <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      second_q   <= second_d;
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      active_q   <= active_d;
      fire_q     <= fire_d;
      drop_q     <= drop_d;
      int_q      <= int_d;
      busy_q     <= busy_d;
      slot_q     <= slot_d;
    end
  end

  assign interrupt   = int_q;
  assign busy        = busy_q;
  assign active_slot = active_q;
  assign fire_cnt    = fire_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_irq_trigger_scheduler.sv
// Directed bench for irq_trigger_scheduler: hand-computed expected pulse
// trains, counter values and slot selections.
module tb_irq_trigger_scheduler;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_pc;
  logic        cfg_en;
  logic        cfg_chain;
  logic        cfg_rearm;
  logic        interrupt;
  logic        busy;
  logic [1:0]  active_slot;
  logic [7:0]  fire_cnt;
  logic [7:0]  drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  irq_trigger_scheduler #(
    .NUM_SLOTS (4),
    .PULSE_LEN (6),
    .GAP_LEN   (1),
    .ADDR_W    (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_pc      (cfg_pc),
    .cfg_en      (cfg_en),
    .cfg_chain   (cfg_chain),
    .cfg_rearm   (cfg_rearm),
    .interrupt   (interrupt),
    .busy        (busy),
    .active_slot (active_slot),
    .fire_cnt    (fire_cnt),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    addr      = '0;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_pc    = '0;
    cfg_en    = 1'b0;
    cfg_chain = 1'b0;
    cfg_rearm = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wr(input int idx, input logic [31:0] pc, input logic en,
                    input logic chain, input logic rearm);
    cfg_we    = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_pc    = pc;
    cfg_en    = en;
    cfg_chain = chain;
    cfg_rearm = rearm;
    tick();
    cfg_we = 1'b0;
  endtask

  // Bit k holds the value sampled after the k-th edge from now (k=0 is now).
  task automatic trace(input int n, output logic [31:0] iv, output logic [31:0] bv);
    iv = '0;
    bv = '0;
    for (int k = 0; k < n; k++) begin
      iv[k] = interrupt;
      bv[k] = busy;
      tick();
    end
  endtask

  logic [31:0] iv, bv;

  initial begin
    // ---- reset state
    do_reset();
    check("rst_int",    {31'd0, interrupt}, 32'd0);
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_active", {30'd0, active_slot}, 32'd0);
    check("rst_fire",   {24'd0, fire_cnt},  32'd0);
    check("rst_drop",   {24'd0, drop_cnt},  32'd0);

    // ---- 1: one-shot slot fires once
    wr(0, 32'h4198, 1'b1, 1'b0, 1'b0);
    addr = 32'h4198;
    tick();
    check("t1_latency", {31'd0, interrupt}, 32'd1);
    addr = '0;
    trace(12, iv, bv);
    check("t1_pulse",   iv, 32'h3F);
    check("t1_fire",    {24'd0, fire_cnt}, 32'd1);
    addr = 32'h4198;
    tick();
    addr = '0;
    trace(10, iv, bv);
    check("t1_oneshot", iv, 32'h0);
    check("t1_fire2",   {24'd0, fire_cnt}, 32'd1);

    // ---- 2: chained pulse 6 high / 1 low / 6 high
    do_reset();
    wr(1, 32'h3000, 1'b1, 1'b1, 1'b1);
    addr = 32'h3000;
    tick();
    addr = '0;
    trace(16, iv, bv);
    check("t2_int",  iv, 32'h1FBF);
    check("t2_busy", bv, 32'h1FFF);
    check("t2_fire", {24'd0, fire_cnt}, 32'd2);

    // ---- 3: priority, pending, drop, back-to-back
    do_reset();
    wr(0, 32'h3000, 1'b1, 1'b0, 1'b1);
    wr(2, 32'h3000, 1'b1, 1'b0, 1'b1);
    wr(3, 32'h3020, 1'b1, 1'b0, 1'b1);
    addr = 32'h3000;
    tick();
    check("t3_prio", {30'd0, active_slot}, 32'd0);
    addr = '0;
    wr(2, 32'h3010, 1'b1, 1'b0, 1'b1);
    addr = 32'h3010;
    tick();
    addr = 32'h3020;
    tick();
    addr = '0;
    check("t3_drop",    {24'd0, drop_cnt}, 32'd1);
    check("t3_active0", {30'd0, active_slot}, 32'd0);
    trace(16, iv, bv);
    check("t3_b2b",     iv, 32'h1FF);
    check("t3_active2", {30'd0, active_slot}, 32'd2);
    check("t3_fire",    {24'd0, fire_cnt}, 32'd2);
    check("t3_idle",    {31'd0, busy}, 32'd0);

    // ---- 4: stalled addr yields one pulse
    do_reset();
    wr(0, 32'h4198, 1'b1, 1'b0, 1'b1);
    addr = 32'h4198;
    iv = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      iv[k] = interrupt;
    end
    check("t4_stall", iv, 32'h3F);
    addr = '0;
    tick();
    addr = 32'h4198;
    tick();
    check("t4_revisit", {31'd0, interrupt}, 32'd1);
    addr = '0;
    trace(10, iv, bv);
    check("t4_pulse2", iv, 32'h3F);
    check("t4_fire",   {24'd0, fire_cnt}, 32'd2);

    // ---- 5: async reset mid-pulse
    do_reset();
    wr(1, 32'h4198, 1'b1, 1'b0, 1'b1);
    addr = 32'h4198;
    tick();
    addr = '0;
    tick();
    tick();
    check("t5_pre_int",    {31'd0, interrupt}, 32'd1);
    check("t5_pre_active", {30'd0, active_slot}, 32'd1);
    reset = 1'b0;
    #1;
    check("t5_int",    {31'd0, interrupt}, 32'd0);
    check("t5_busy",   {31'd0, busy},      32'd0);
    check("t5_active", {30'd0, active_slot}, 32'd0);
    check("t5_fire",   {24'd0, fire_cnt},  32'd0);
    check("t5_drop",   {24'd0, drop_cnt},  32'd0);
    #1;
    reset = 1'b1;
    tick();
    addr = 32'h4198;
    tick();
    addr = '0;
    trace(8, iv, bv);
    check("t5_cleared", iv, 32'h0);
    check("t5_fire2",   {24'd0, fire_cnt}, 32'd0);

    // ---- 6: rewrite during pulse re-arms a one-shot without aborting
    do_reset();
    wr(0, 32'h4198, 1'b1, 1'b0, 1'b0);
    addr = 32'h4198;
    tick();
    iv = '0;
    iv[0] = interrupt;
    addr = '0;
    tick();
    iv[1] = interrupt;
    wr(0, 32'h4198, 1'b1, 1'b0, 1'b0);
    iv[2] = interrupt;
    for (int k = 3; k < 13; k++) begin
      tick();
      iv[k] = interrupt;
    end
    check("t6_intact", iv, 32'h3F);
    addr = 32'h4198;
    tick();
    check("t6_refire", {31'd0, interrupt}, 32'd1);
    addr = '0;
    trace(10, iv, bv);
    check("t6_pulse2", iv, 32'h3F);
    check("t6_fire",   {24'd0, fire_cnt}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
